// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the two-requester ALU arbiter.
//   - op_code localparams (OP_ADD..OP_SHLB) understood by the ALU datapath
//   - state_e: encoding of the arbiter's response-register FSM
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_GT   = 3'b101;
    localparam logic [2:0] OP_SHLA = 3'b110;
    localparam logic [2:0] OP_SHLB = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,   // response register empty
        ST_RESP = 1'b1    // response register holds a result
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: purely combinational 8-bit ALU datapath.
// Ports:
//   op    in  3  op_code (see alu_pkg)
//   a, b  in  8  operands
//   res   out 8  result
//   carry out 1  carry for add, no-borrow for sub, 0 for every other op
//   gt    out 1  unsigned a > b, independent of op
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] res,
    output logic       carry,
    output logic       gt
);

    logic [8:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};
    assign gt  = (a > b);

    always_comb begin
        res   = 8'h00;
        carry = 1'b0;   // cleared for non-arithmetic ops so no stale carry leaks out
        case (op)
            OP_ADD: begin
                res   = sum[7:0];
                carry = sum[8];
            end
            OP_SUB: begin
                res   = a - b;
                carry = (a >= b);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_GT:   res = {7'b0, gt};
            OP_SHLA: res = {a[6:0], 1'b0};
            OP_SHLB: res = {b[6:0], 1'b0};
            default: res = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through round-robin arbitration.
// An accepted op is evaluated in the accept cycle and registered, so the
// result appears one cycle later. A held response can be replaced in the
// same cycle it is consumed, giving one op per cycle throughput.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rX_valid/rX_ready             request handshake for requester X
//   rX_op, rX_a, rX_b             op_code and operands (held until ready)
//   rsp_valid/rsp_ready           response handshake
//   rsp_id, rsp_out               issuing requester and result
//   rsp_carry, rsp_zero, rsp_cflag  carry, result==0, unsigned a>b
//   gnt_cnt0, gnt_cnt1            saturating accept counters
// Optional feature: define ALU_ARB_STATS_EN to add gnt_cnt0/gnt_cnt1 (width CNT_W).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [2:0] r0_op,
    input  logic [7:0] r0_a,
    input  logic [7:0] r0_b,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [2:0] r1_op,
    input  logic [7:0] r1_a,
    input  logic [7:0] r1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_out,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_cflag
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;           // requester favoured on contention
    logic       id_q, id_d;
    logic [7:0] out_q, out_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;
    logic       cflag_q, cflag_d;

    logic       cap, accept, gnt;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_res;
    logic       alu_carry, alu_gt;

    // Accept is possible when the register is empty or being drained this
    // cycle; reset blocks it so nothing is taken while rst is high.
    assign cap    = !rst && ((state_q == ST_IDLE) || rsp_ready);
    assign gnt    = r1_valid && (!r0_valid || ptr_q);
    assign accept = cap && (r0_valid || r1_valid);

    assign r0_ready = accept && !gnt;
    assign r1_ready = accept &&  gnt;

    assign alu_op = gnt ? r1_op : r0_op;
    assign alu_a  = gnt ? r1_a  : r0_a;
    assign alu_b  = gnt ? r1_b  : r0_b;

    alu_arbiter_alu u_alu (
        .op    (alu_op),
        .a     (alu_a),
        .b     (alu_b),
        .res   (alu_res),
        .carry (alu_carry),
        .gt    (alu_gt)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        out_d   = out_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        cflag_d = cflag_q;
        if (accept) begin
            state_d = ST_RESP;
            ptr_d   = !gnt;             // favour the loser next time
            id_d    = gnt;
            out_d   = alu_res;
            carry_d = alu_carry;
            zero_d  = (alu_res == 8'h00);
            cflag_d = alu_gt;
        end else if (state_q == ST_RESP && rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            out_q   <= 8'h00;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            cflag_q <= cflag_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_out   = out_q;
    assign rsp_carry = carry_q;
    assign rsp_zero  = zero_q;
    assign rsp_cflag = cflag_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (r0_ready && cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + 1'b1;
        if (r1_ready && cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] out;
        logic       carry;
        logic       zero;
        logic       cflag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r0_valid = 1'b0, r1_valid = 1'b0;
    logic       r0_ready, r1_ready;
    logic [2:0] r0_op = '0, r1_op = '0;
    logic [7:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_id;
    logic [7:0] rsp_out;
    logic       rsp_carry, rsp_zero, rsp_cflag;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t sb[$];
    logic m_ptr  = 1'b0;
    logic m_acc0 = 1'b0;
    logic m_acc1 = 1'b0;

    always #5 clk = ~clk;

`ifdef ALU_ARB_STATS_EN
    logic [1:0] gnt_cnt0, gnt_cnt1;
    alu_arbiter #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_cflag(rsp_cflag),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );
`else
    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_cflag(rsp_cflag)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t model(input logic id, input logic [2:0] op,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   s;
        e = '0;
        e.id = id;
        e.cflag = (a > b);
        case (op)
            3'd0: begin s = int'(a) + int'(b); e.out = s[7:0]; e.carry = (s > 255); end
            3'd1: begin s = int'(a) - int'(b); e.out = s[7:0]; e.carry = (s >= 0);  end
            3'd2: e.out = a & b;
            3'd3: e.out = a | b;
            3'd4: e.out = a ^ b;
            3'd5: e.out = (a > b) ? 8'd1 : 8'd0;
            3'd6: begin s = int'(a) * 2; e.out = s[7:0]; end
            default: begin s = int'(b) * 2; e.out = s[7:0]; end
        endcase
        e.zero = (e.out == 8'h00);
        return e;
    endfunction

    // Reference model + scoreboard, evaluated mid-cycle on stable inputs.
    always @(negedge clk) begin
        logic cap, g1, acc;
        exp_t e;
        if (rst) begin
            chk("ready0_in_rst", r0_ready, 1'b0);
            chk("ready1_in_rst", r1_ready, 1'b0);
            sb.delete();
            m_ptr = 1'b0; m_acc0 = 1'b0; m_acc1 = 1'b0;
        end else begin
            chk("rsp_valid", rsp_valid, sb.size() != 0);
            if (sb.size() != 0) begin
                e = sb[0];
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_out", rsp_out, e.out);
                chk("rsp_carry", rsp_carry, e.carry);
                chk("rsp_zero", rsp_zero, e.zero);
                chk("rsp_cflag", rsp_cflag, e.cflag);
            end
            cap = (sb.size() == 0) || rsp_ready;
            g1  = r1_valid && (!r0_valid || m_ptr);
            acc = cap && (r0_valid || r1_valid);
            chk("r0_ready", r0_ready, acc && !g1);
            chk("r1_ready", r1_ready, acc && g1);
            m_acc0 = acc && !g1;
            m_acc1 = acc && g1;
            if (sb.size() != 0 && rsp_ready) void'(sb.pop_front());
            if (acc) begin
                sb.push_back(g1 ? model(1'b1, r1_op, r1_a, r1_b) : model(1'b0, r0_op, r0_a, r0_b));
                m_ptr = !g1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_r0(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        r0_valid = v; r0_op = op; r0_a = a; r0_b = b;
    endtask

    task automatic set_r1(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        r1_valid = v; r1_op = op; r1_a = a; r1_b = b;
    endtask

    logic [3:0] ids;

    initial begin
        // reset state
        do_reset();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_out", rsp_out, 8'h00);
        chk("rst_flags", {rsp_carry, rsp_zero, rsp_cflag}, 3'b000);

        // single op: F0 + 20
        rsp_ready = 1'b1;
        set_r0(1'b1, 3'd0, 8'hF0, 8'h20);
        step();
        r0_valid = 1'b0;
        chk("single_valid", rsp_valid, 1'b1);
        chk("single_id", rsp_id, 1'b0);
        chk("single_out", rsp_out, 8'h10);
        chk("single_flags", {rsp_carry, rsp_zero, rsp_cflag}, 3'b101);
        step();

        // carry must not leak from an add into a following logic op
        set_r0(1'b1, 3'd0, 8'hFF, 8'h01);
        step();
        set_r0(1'b1, 3'd2, 8'h0F, 8'h0F);
        chk("sc_add_out", rsp_out, 8'h00);
        chk("sc_add_carry", rsp_carry, 1'b1);
        step();
        set_r0(1'b1, 3'd1, 8'h05, 8'h05);
        chk("sc_and_out", rsp_out, 8'h0F);
        chk("sc_and_carry", rsp_carry, 1'b0);
        step();
        r0_valid = 1'b0;
        chk("sc_sub_out", rsp_out, 8'h00);
        chk("sc_sub_zc", {rsp_zero, rsp_carry}, 2'b11);
        step();

        // backpressure
        set_r0(1'b1, 3'd0, 8'h03, 8'h04);
        step();
        r0_valid = 1'b0;
        rsp_ready = 1'b0;
        set_r1(1'b1, 3'd4, 8'hAA, 8'h55);
        for (int i = 0; i < 3; i++) begin
            chk("bp_r1_ready", r1_ready, 1'b0);
            chk("bp_hold_out", rsp_out, 8'h07);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", r1_ready, 1'b1);
        step();
        r1_valid = 1'b0;
        chk("bp_new_out", rsp_out, 8'hFF);
        chk("bp_new_id", rsp_id, 1'b1);
        step();

        // contention from reset: ids alternate 0,1,0,1
        rst = 1'b1;
        step();
        set_r0(1'b1, 3'd0, 8'h01, 8'h02);
        set_r1(1'b1, 3'd1, 8'h09, 8'h03);
        rsp_ready = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            ids[i] = rsp_id;
        end
        chk("rr_id_seq", ids, 4'b1010);
        r0_valid = 1'b0; r1_valid = 1'b0;
        step();

        // reset with a held response; pointer returns to requester 0
        set_r0(1'b1, 3'd3, 8'h30, 8'h03);
        step();
        r0_valid = 1'b0;
        rsp_ready = 1'b0;
        step();
        chk("mid_held", rsp_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", rsp_valid, 1'b0);
        set_r0(1'b1, 3'd6, 8'h81, 8'h00);
        set_r1(1'b1, 3'd7, 8'h00, 8'h41);
        #1;
        chk("mid_r0_gnt", {r0_ready, r1_ready}, 2'b10);
        rsp_ready = 1'b1;
        step();
        r0_valid = 1'b0; r1_valid = 1'b0;
        step();

        // random traffic; requesters hold until accepted
        for (int i = 0; i < 400; i++) begin
            if (!r0_valid || m_acc0)
                set_r0(($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom));
            if (!r1_valid || m_acc1)
                set_r1(($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom));
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
        step();
        step();
        chk("sb_drained", sb.size(), 0);

`ifdef ALU_ARB_STATS_EN
        do_reset();
        chk("cnt_rst", {gnt_cnt1, gnt_cnt0}, 4'b0000);
        rsp_ready = 1'b1;
        set_r0(1'b1, 3'd2, 8'h11, 8'h22);
        for (int i = 0; i < 5; i++) step();
        r0_valid = 1'b0;
        chk("cnt0_sat", gnt_cnt0, 2'd3);
        chk("cnt1_zero", gnt_cnt1, 2'd0);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
